// File: rtl/biquad_filter.sv
// Time-multiplexed direct-form-I biquad: one shared multiplier walks the five
// taps in sequence, so a new sample can be accepted every 7 clocks.
module biquad_filter #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int FRAC_W = 16,
  parameter int ACC_W  = DATA_W + COEF_W + 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clear_i,
  input  logic [1:0]               mode_i,
  input  logic signed [COEF_W-1:0] b0_i,
  input  logic signed [COEF_W-1:0] b1_i,
  input  logic signed [COEF_W-1:0] b2_i,
  input  logic signed [COEF_W-1:0] a1_i,
  input  logic signed [COEF_W-1:0] a2_i,
  input  logic                     valid_i,
  input  logic signed [DATA_W-1:0] data_i,
  output logic                     ready_o,
  output logic                     valid_o,
  output logic signed [DATA_W-1:0] data_o,
  output logic                     sat_o
);

  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic [1:0] MODE_MUTE   = 2'd0;
  localparam logic [1:0] MODE_BYPASS = 2'd1;
  localparam logic [1:0] MODE_FIR    = 2'd2;

  localparam logic signed [ACC_W-1:0] ROUND_INIT =
    {{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] MAX_A =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_A =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state;
  state_t state_nxt;

  logic [2:0]               step;
  logic [1:0]               mode_cap;
  logic signed [DATA_W-1:0] x_cap;
  logic signed [COEF_W-1:0] b0_cap;
  logic signed [COEF_W-1:0] b1_cap;
  logic signed [COEF_W-1:0] b2_cap;
  logic signed [COEF_W-1:0] a1_cap;
  logic signed [COEF_W-1:0] a2_cap;
  logic signed [DATA_W-1:0] x1;
  logic signed [DATA_W-1:0] x2;
  logic signed [DATA_W-1:0] y1;
  logic signed [DATA_W-1:0] y2;
  logic signed [ACC_W-1:0]  acc;

  logic signed [COEF_W-1:0] coef_sel;
  logic signed [DATA_W-1:0] samp_sel;
  logic                     sub_sel;
  logic                     zero_sel;
  logic signed [PROD_W-1:0] coef_ext;
  logic signed [PROD_W-1:0] samp_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [DATA_W-1:0] res;
  logic                     res_sat;
  logic [DATA_W:0]          rs;

  // Drop the fraction (rounding bias was preloaded into the accumulator) and clamp.
  function automatic logic [DATA_W:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
    sh = a >>> FRAC_W;
    if (sh > MAX_A)
      return {1'b1, MAX_A[DATA_W-1:0]};
    else if (sh < MIN_A)
      return {1'b1, MIN_A[DATA_W-1:0]};
    else
      return {1'b0, sh[DATA_W-1:0]};
  endfunction

  assign ready_o = (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_i) state_nxt = MAC;
      MAC:     if (step == 3'd4) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      state <= IDLE;
    else if (clear_i)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Tap selection for the shared multiplier; feedback taps are subtracted.
  always_comb begin
    coef_sel = b0_cap;
    samp_sel = x_cap;
    sub_sel  = 1'b0;
    zero_sel = 1'b0;
    case (step)
      3'd0: begin coef_sel = b0_cap; samp_sel = x_cap; end
      3'd1: begin coef_sel = b1_cap; samp_sel = x1;    end
      3'd2: begin coef_sel = b2_cap; samp_sel = x2;    end
      3'd3: begin coef_sel = a1_cap; samp_sel = y1; sub_sel = 1'b1; end
      3'd4: begin coef_sel = a2_cap; samp_sel = y2; sub_sel = 1'b1; end
      default: zero_sel = 1'b1;
    endcase
    if (sub_sel && (mode_cap == MODE_FIR))
      zero_sel = 1'b1;
  end

  always_comb begin
    coef_ext = {{DATA_W{coef_sel[COEF_W-1]}}, coef_sel};
    samp_ext = {{COEF_W{samp_sel[DATA_W-1]}}, samp_sel};
    prod     = coef_ext * samp_ext;
    prod_ext = zero_sel ? '0 : {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    acc_nxt  = sub_sel ? (acc - prod_ext) : (acc + prod_ext);
  end

  always_comb begin
    rs      = round_sat(acc);
    res     = rs[DATA_W-1:0];
    res_sat = rs[DATA_W];
    case (mode_cap)
      MODE_MUTE:   begin res = '0;    res_sat = 1'b0; end
      MODE_BYPASS: begin res = x_cap; res_sat = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      step     <= '0;
      mode_cap <= '0;
      x_cap    <= '0;
      b0_cap   <= '0;
      b1_cap   <= '0;
      b2_cap   <= '0;
      a1_cap   <= '0;
      a2_cap   <= '0;
      x1       <= '0;
      x2       <= '0;
      y1       <= '0;
      y2       <= '0;
      acc      <= '0;
      valid_o  <= 1'b0;
      sat_o    <= 1'b0;
      data_o   <= '0;
    end else if (clear_i) begin
      step    <= '0;
      x1      <= '0;
      x2      <= '0;
      y1      <= '0;
      y2      <= '0;
      acc     <= '0;
      valid_o <= 1'b0;
      sat_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      sat_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            mode_cap <= mode_i;
            x_cap    <= data_i;
            b0_cap   <= b0_i;
            b1_cap   <= b1_i;
            b2_cap   <= b2_i;
            a1_cap   <= a1_i;
            a2_cap   <= a2_i;
            acc      <= ROUND_INIT;
            step     <= '0;
          end
        end
        MAC: begin
          acc  <= acc_nxt;
          step <= step + 3'd1;
        end
        OUT: begin
          data_o  <= res;
          sat_o   <= res_sat;
          valid_o <= 1'b1;
          if (mode_cap == MODE_MUTE) begin
            x1 <= '0;
            x2 <= '0;
            y1 <= '0;
            y2 <= '0;
          end else begin
            x2 <= x1;
            x1 <= x_cap;
            y2 <= y1;
            y1 <= res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_filter.sv
// Directed-vector bench for biquad_filter: table of single samples plus
// hand-written reset, handshake and clear sequences.
module tb_biquad_filter;

  localparam int DW = 16;
  localparam int CW = 18;

  logic                 clk_i;
  logic                 reset_i;
  logic                 clear_i;
  logic [1:0]           mode_i;
  logic signed [CW-1:0] b0_i, b1_i, b2_i, a1_i, a2_i;
  logic                 valid_i;
  logic signed [DW-1:0] data_i;
  logic                 ready_o;
  logic                 valid_o;
  logic signed [DW-1:0] data_o;
  logic                 sat_o;

  int checks = 0;
  int errors = 0;

  biquad_filter #(.DATA_W(DW), .COEF_W(CW), .FRAC_W(16)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .mode_i  (mode_i),
    .b0_i    (b0_i),
    .b1_i    (b1_i),
    .b2_i    (b2_i),
    .a1_i    (a1_i),
    .a2_i    (a2_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .sat_o   (sat_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    string      name;
    logic       clr;
    logic [1:0] mode;
    int         b0, b1, b2, a1, a2;
    int         x;
    int         exp_y;
    logic       exp_sat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk_i);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
  endtask

  // Issues one sample from idle and waits (bounded) for its output pulse.
  task automatic run_sample(input logic [1:0] m, input int c0, input int c1, input int c2,
                            input int ca1, input int ca2, input int x,
                            output int lat, output int y, output logic s);
    lat = -1;
    y   = 0;
    s   = 1'b0;
    @(negedge clk_i);
    mode_i  = m;
    b0_i    = c0[CW-1:0];
    b1_i    = c1[CW-1:0];
    b2_i    = c2[CW-1:0];
    a1_i    = ca1[CW-1:0];
    a2_i    = ca2[CW-1:0];
    data_i  = x[DW-1:0];
    valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    mode_i  = 2'd0;
    b0_i = '0; b1_i = '0; b2_i = '0; a1_i = '0; a2_i = '0;
    data_i  = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_i);
      #1;
      if (valid_o) begin
        lat = k;
        y   = data_o;
        s   = sat_o;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int y;
    logic s;
    int cnt;
    int pos[$];

    vecs[0]  = '{"byp_1234", 1'b1, 2'd1, 0, 0, 0, 0, 0, 1234, 1234, 1'b0};
    vecs[1]  = '{"byp_m5",   1'b0, 2'd1, 0, 0, 0, 0, 0, -5, -5, 1'b0};
    vecs[2]  = '{"mute",     1'b0, 2'd0, 65536, 0, 0, 0, 0, 777, 0, 1'b0};
    vecs[3]  = '{"fir_a",    1'b1, 2'd2, 32768, 32768, 0, -99999, -99999, 1000, 500, 1'b0};
    vecs[4]  = '{"fir_b",    1'b0, 2'd2, 32768, 32768, 0, -99999, -99999, 1000, 1000, 1'b0};
    vecs[5]  = '{"iir_a",    1'b1, 2'd3, 65536, 0, 0, -32768, 0, 1000, 1000, 1'b0};
    vecs[6]  = '{"iir_b",    1'b0, 2'd3, 65536, 0, 0, -32768, 0, 0, 500, 1'b0};
    vecs[7]  = '{"iir_c",    1'b0, 2'd3, 65536, 0, 0, -32768, 0, 0, 250, 1'b0};
    vecs[8]  = '{"mute_h",   1'b0, 2'd0, 65536, 65536, 0, -32768, 0, 9, 0, 1'b0};
    vecs[9]  = '{"post_mute",1'b0, 2'd3, 65536, 65536, 0, -32768, 0, 0, 0, 1'b0};
    vecs[10] = '{"sat_pos",  1'b1, 2'd3, 131071, 0, 0, 0, 0, 32767, 32767, 1'b1};
    vecs[11] = '{"sat_neg",  1'b0, 2'd3, 131071, 0, 0, 0, 0, -32768, -32768, 1'b1};
    vecs[12] = '{"round_neg",1'b1, 2'd3, 65536, 0, 0, 0, 0, -7, -7, 1'b0};

    reset_i = 1'b1;
    clear_i = 1'b0;
    valid_i = 1'b0;
    mode_i  = 2'd0;
    b0_i = '0; b1_i = '0; b2_i = '0; a1_i = '0; a2_i = '0;
    data_i  = '0;

    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ready", ready_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_data",  data_o,  0);
    check("rst_sat",   sat_o,   0);
    @(negedge clk_i);
    reset_i = 1'b0;

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].clr) pulse_clear();
      run_sample(vecs[i].mode, vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].a1, vecs[i].a2,
                 vecs[i].x, lat, y, s);
      check({vecs[i].name, "_lat"},  lat, 6);
      check({vecs[i].name, "_data"}, y,   vecs[i].exp_y);
      check({vecs[i].name, "_sat"},  s,   vecs[i].exp_sat);
    end
    check("ready_after_out", ready_o, 1);

    // Reset in the middle of the MAC phase.
    @(negedge clk_i);
    mode_i = 2'd1; data_i = 16'sd555; valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    check("busy_ready", ready_o, 0);
    #2 reset_i = 1'b1;
    #1;
    check("midrst_ready", ready_o, 1);
    check("midrst_valid", valid_o, 0);
    check("midrst_data",  data_o,  0);
    @(negedge clk_i);
    reset_i = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk_i);
      #1;
      if (valid_o) cnt++;
    end
    check("midrst_no_out", cnt, 0);

    // valid_i held high: acceptances only every 7 cycles.
    @(negedge clk_i);
    mode_i = 2'd1; data_i = 16'sd42; valid_i = 1'b1;
    for (int k = 0; k < 28; k++) begin
      @(posedge clk_i);
      #1;
      if (valid_o) pos.push_back(k);
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    check("hold_count", pos.size(), 4);
    for (int i = 0; i < pos.size(); i++)
      check("hold_pos", pos[i], 6 + 7 * i);
    check("hold_data", data_o, 42);

    // Clear at E3 aborts the sample and wipes history.
    pulse_clear();
    run_sample(2'd3, 65536, 0, 0, -32768, 0, 1000, lat, y, s);
    check("clr_pre_data", y, 1000);
    @(negedge clk_i);
    mode_i = 2'd3; b0_i = 18'sd65536; a1_i = -18'sd32768; data_i = 16'sd2000; valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("clr_ready", ready_o, 1);
    @(negedge clk_i);
    clear_i = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_i);
      #1;
      if (valid_o) cnt++;
    end
    check("clr_no_out", cnt, 0);
    run_sample(2'd3, 65536, 0, 0, -32768, 0, 300, lat, y, s);
    check("clr_post_lat",  lat, 6);
    check("clr_post_data", y,   300);
    check("clr_post_sat",  s,   0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/biquad_filter.md
BIQUAD_FILTER -- requirements
Module: biquad_filter

Interface
REQ-001 Parameter DATA_W, default 16, sample width (signed two's complement).
REQ-002 Parameter COEF_W, default 18, coefficient width (signed).
REQ-003 Parameter FRAC_W, default 16, fractional bits of coefficients (unity = 2^FRAC_W).
REQ-004 Parameter ACC_W, default DATA_W+COEF_W+3, accumulator width.
REQ-005 clk_i  in  1  single system clock; all logic on rising edge.
REQ-006 reset_i  in  1  reset, asynchronous, active-high.
REQ-007 clear_i  in  1  synchronous clear of history and in-flight computation.
REQ-008 mode_i  in  2  0 mute, 1 bypass, 2 FIR (b terms only), 3 IIR (full biquad).
REQ-009 b0_i, b1_i, b2_i, a1_i, a2_i  in  COEF_W each  signed coefficients.
REQ-010 valid_i  in  1  input sample strobe; data_i  in  DATA_W  input sample.
REQ-011 ready_o  out  1  high when idle and able to accept a sample.
REQ-012 valid_o  out  1  one-cycle pulse, data_o valid; data_o  out  DATA_W  output sample.
REQ-013 sat_o  out  1  pulses with valid_o when the output was clamped.

Function
REQ-014 States: IDLE, MAC, OUT; ready_o SHALL be high exactly in IDLE.
REQ-015 Acceptance: valid_i && ready_o at edge E0 SHALL capture data_i, mode_i and all five coefficients; valid_i while not ready SHALL be ignored (no queueing).
REQ-016 MAC: edges E1..E5 SHALL accumulate, one product per edge via one shared multiplier, b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2, in that order; accumulator starts at 2^(FRAC_W-1) (round half up).
REQ-017 Mode 2 SHALL force the a1/a2 products to zero; modes 0 and 1 SHALL still spend E1..E5 (uniform latency).
REQ-018 At E6: result = accumulator arithmetic-shift-right FRAC_W, clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; sat_o=1 iff clamped.
REQ-019 Mode 1: data_o SHALL equal captured x exactly, sat_o=0; mode 0: data_o SHALL be 0, sat_o=0.
REQ-020 At E6 valid_o SHALL rise for exactly one cycle (cleared at E7); data_o SHALL hold until the next E6.
REQ-021 At E6 state SHALL return to IDLE; ready_o high after E6; earliest next acceptance E7 (throughput 1 sample / 7 cycles).
REQ-022 History update at E6: x2<=x1, x1<=x, y2<=y1, y1<=data_o value; in mode 0 all four history registers SHALL be set to 0.
REQ-023 Mode/coefficient changes SHALL affect only samples accepted afterwards; history is not cleared on mode change.
REQ-024 ACC_W SHALL be sized so the five-term sum cannot wrap; only the final result saturates.
REQ-025 clear_i high at an edge SHALL abort any computation (no valid_o for it), zero history and accumulator, go to IDLE; clear_i has priority over a simultaneous valid_i.

Reset
REQ-026 reset_i high SHALL asynchronously force IDLE, ready_o=1, valid_o=0, sat_o=0, data_o=0, accumulator and all history to 0.
REQ-027 Reset mid-computation SHALL discard the sample; no valid_o after release until a new acceptance.

Verification
REQ-028 Reset: assert reset_i mid-MAC -> immediately ready_o=1, valid_o=0, data_o=0; no later valid_o for that sample.
REQ-029 Bypass: mode 1, x=1234 -> valid_o at E6, data_o=1234, sat_o=0; x=-5 -> -5.
REQ-030 FIR: mode 2, b0=b1=32768, b2=0, a1=a2=-99999 (ignored); x=1000,1000 -> 500, 1000.
REQ-031 IIR: mode 3, b0=65536, a1=-32768, others 0; x=1000,0,0 -> 1000, 500, 250.
REQ-032 Saturation: mode 3, b0=131071, others 0; x=32767 -> 32767, sat_o=1; x=-32768 -> -32768, sat_o=1.
REQ-033 Handshake/clear: valid_i held high continuously -> acceptances every 7 cycles only; clear_i at E3 -> no valid_o, ready_o=1 next cycle, next IIR output equals b0*x scaled (history zero).
